// File: rtl/accum_cpu_gen2.sv
// ============================================================================
// Module   : accum_cpu_gen2
// Brief    : Parametrised accumulator processor with load/run handshake,
//            zero/carry flags, carry arithmetic and conditional jumps.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module accum_cpu_gen2 #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW+3:0] wr_data,
  input  logic          start,
  output logic [DW-1:0] ac,
  output logic [AW-1:0] pc,
  output logic          zf,
  output logic          cf,
  output logic          busy,
  output logic          halted
);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LOAD = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_SHR  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_JZ   = 4'hC;
  localparam logic [3:0] OP_JC   = 4'hD;
  localparam logic [3:0] OP_ADC  = 4'hE;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  state_t        state;
  logic [DW+3:0] mem [2**AW];
  logic [DW+3:0] ir;

  logic [3:0]    opcode;
  logic [DW-1:0] opnd;
  logic [DW-1:0] alu_ac;
  logic          alu_cf;
  logic          upd_z;
  logic          jump;
  logic          loadable;

  assign opcode   = ir[DW+3:DW];
  assign opnd     = ir[DW-1:0];
  assign loadable = (state == S_IDLE) || (state == S_HALT);

  // Program memory has no reset so a loaded program survives a reset.
  always_ff @(posedge clk) begin
    if (we && loadable) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    alu_ac = ac;
    alu_cf = cf;
    upd_z  = 1'b0;
    jump   = 1'b0;
    case (opcode)
      OP_LOAD: begin alu_ac = opnd;        upd_z = 1'b1; end
      OP_ADD:  begin {alu_cf, alu_ac} = {1'b0, ac} + {1'b0, opnd}; upd_z = 1'b1; end
      OP_SUB:  begin
        alu_ac = ac - opnd;
        alu_cf = (ac < opnd);
        upd_z  = 1'b1;
      end
      OP_AND:  begin alu_ac = ac & opnd;   upd_z = 1'b1; end
      OP_OR:   begin alu_ac = ac | opnd;   upd_z = 1'b1; end
      OP_XOR:  begin alu_ac = ac ^ opnd;   upd_z = 1'b1; end
      OP_NOT:  begin alu_ac = ~ac;         upd_z = 1'b1; end
      OP_SHL:  begin
        alu_cf = ac[DW-1];
        alu_ac = {ac[DW-2:0], 1'b0};
        upd_z  = 1'b1;
      end
      OP_SHR:  begin
        alu_cf = ac[0];
        alu_ac = {1'b0, ac[DW-1:1]};
        upd_z  = 1'b1;
      end
      OP_JMP:  jump = 1'b1;
      OP_JZ:   jump = zf;
      OP_JC:   jump = cf;
      OP_ADC:  begin
        {alu_cf, alu_ac} = {1'b0, ac} + {1'b0, opnd} + {{DW{1'b0}}, cf};
        upd_z = 1'b1;
      end
      default: begin end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      ir     <= '0;
      ac     <= '0;
      pc     <= '0;
      zf     <= 1'b0;
      cf     <= 1'b0;
      busy   <= 1'b0;
      halted <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            state  <= S_FETCH;
            ac     <= '0;
            pc     <= '0;
            zf     <= 1'b0;
            cf     <= 1'b0;
            busy   <= 1'b1;
            halted <= 1'b0;
          end
        end
        S_FETCH: begin
          ir    <= mem[pc];
          pc    <= pc + 1'b1;
          state <= S_DECODE;
        end
        S_DECODE: state <= S_EXECUTE;
        S_EXECUTE: begin
          ac <= alu_ac;
          cf <= alu_cf;
          if (upd_z) zf <= (alu_ac == '0);
          // Jump target is the low AW bits of the operand (AW <= DW assumed).
          if (jump) pc <= opnd[AW-1:0];
          if (opcode == OP_HALT) begin
            state  <= S_HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
            state <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
